// File: rtl/pattern_hflipper.sv
// rtl/pattern_hflipper.sv - conditional left<->right pixel mirror of one pattern line
// Optional output register: define PATTERN_HFLIPPER_REG_EN for 1-cycle registered output.
module pattern_hflipper #(
  parameter int PIXEL_W = 2,
  parameter int NPIXELS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PIXEL_W*NPIXELS-1:0]   line_in,
  input  logic                         hflip,
  output logic [PIXEL_W*NPIXELS-1:0]   line_out
);

  localparam int LINE_W = PIXEL_W * NPIXELS;

  logic [LINE_W-1:0] w_mirror;
  logic [LINE_W-1:0] w_next;

  // Reverse the order of whole pixels; bits inside a pixel keep their order.
  always_comb begin
    w_mirror = '0;
    for (int i = 0; i < NPIXELS; i++) begin
      w_mirror[i*PIXEL_W +: PIXEL_W] = line_in[(NPIXELS-1-i)*PIXEL_W +: PIXEL_W];
    end
  end

  assign w_next = hflip ? w_mirror : line_in;

`ifdef PATTERN_HFLIPPER_REG_EN
  logic [LINE_W-1:0] r_line_out;

  // Register the selected line; reset wins over incoming data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_out <= '0;
    end else begin
      r_line_out <= w_next;
    end
  end

  assign line_out = r_line_out;
`else
  // Combinational build: clock and reset intentionally do not touch the data path.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;

  assign line_out = w_next;
`endif

endmodule

// File: tb/tb_pattern_hflipper.sv
// tb/tb_pattern_hflipper.sv - self-checking bench for pattern_hflipper
module tb_pattern_hflipper;

  logic        clk;
  logic        rst;
  logic [15:0] line_in;
  logic        hflip;
  logic [15:0] line_out;

  int n_cmp;
  int n_fail;

  pattern_hflipper #(.PIXEL_W(2), .NPIXELS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .line_in  (line_in),
    .hflip    (hflip),
    .line_out (line_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] li;
    logic        hf;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  // Reference: extract pixel p as a number, place it at position 7-p.
  function automatic logic [15:0] ref_flip(input logic [15:0] x, input logic h);
    int pix[8];
    int acc;
    for (int p = 0; p < 8; p++) pix[p] = (int'(x) / (4 ** (7 - p))) % 4;
    if (!h) return x;
    acc = 0;
    for (int p = 0; p < 8; p++) acc = acc + pix[7 - p] * (4 ** (7 - p));
    return acc[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] li, input logic hf, output logic [15:0] got);
`ifdef PATTERN_HFLIPPER_REG_EN
    @(negedge clk);
    line_in = li;
    hflip   = hf;
    @(posedge clk);
    #1;
    got = line_out;
`else
    line_in = li;
    hflip   = hf;
    #1;
    got = line_out;
`endif
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] got2;
    logic [15:0] x;
    logic        h;

    n_cmp  = 0;
    n_fail = 0;
    rst     = 1'b0;
    line_in = 16'h0000;
    hflip   = 1'b0;

    vecs[0] = '{16'b00_01_00_10_00_11_00_01, 1'b0, 16'b00_01_00_10_00_11_00_01, "pass_through"};
    vecs[1] = '{16'b00_01_00_10_00_11_00_01, 1'b1, 16'b01_00_11_00_10_00_01_00, "flip_example"};
    vecs[2] = '{16'b11_00_11_00_11_00_11_00, 1'b1, 16'b00_11_00_11_00_11_00_11, "flip_alt"};
    vecs[3] = '{16'b00_01_10_11_11_10_01_00, 1'b1, 16'b00_01_10_11_11_10_01_00, "palindrome"};
    vecs[4] = '{16'h4000,                     1'b1, 16'h0001,                     "not_bitrev"};
    vecs[5] = '{16'h4000,                     1'b0, 16'h4000,                     "msb_pass"};
    vecs[6] = '{16'h1234,                     1'b1, 16'h1C84,                     "flip_1234"};
    vecs[7] = '{16'hC000,                     1'b1, 16'h0003,                     "flip_c000"};

`ifdef PATTERN_HFLIPPER_REG_EN
    // Reset held for two edges, then first line appears exactly one edge later.
    rst     = 1'b1;
    line_in = 16'h1234;
    hflip   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_zero", line_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("edge0_still_zero", line_out, 16'h0000);
    @(posedge clk);
    #1;
    check("first_after_reset", line_out, 16'h1C84);

    // Reset mid-stream drops the line sampled on that edge.
    @(negedge clk);
    line_in = 16'hABCD;
    hflip   = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check("midstream_reset", line_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_midstream", line_out, 16'hABCD);
`else
    // With reset asserted and clock running, output still follows inputs.
    rst = 1'b1;
    drive(16'h1234, 1'b1, got);
    check("rst_no_effect", got, 16'h1C84);
    @(posedge clk);
    @(negedge clk);
    check("clk_no_effect", line_out, 16'h1C84);
    rst = 1'b0;
    drive(16'h1234, 1'b0, got);
    check("same_cycle_follow", got, 16'h1234);
`endif

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].li, vecs[i].hf, got);
      check(vecs[i].name, got, vecs[i].exp);
    end

`ifndef PATTERN_HFLIPPER_REG_EN
    // Every 17-bit input combination against the reference.
    for (int v = 0; v < 131072; v++) begin
      x = v[15:0];
      h = v[16];
      drive(x, h, got);
      check("exhaustive", got, ref_flip(x, h));
    end
`endif

    // Random lines: reference match and flip-twice identity.
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      h = 1'($urandom);
      drive(x, h, got);
      check("random", got, ref_flip(x, h));
      drive(x, 1'b1, got);
      drive(got, 1'b1, got2);
      check("involution", got2, x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
